// File: rtl/stream_encrypt_if.sv
// Handshake/bus bundle for stream_encrypt: key load, plaintext in, ciphertext out.
interface stream_encrypt_if #(
  parameter int n = 8
);
  logic [n-1:0] password;
  logic         start;
  logic [n-1:0] data_in;
  logic         in_valid;
  logic         in_ready;
  logic [n-1:0] data_out;
  logic         out_valid;
  logic         init_done;

  modport master (
    output password, start, data_in, in_valid,
    input  in_ready, data_out, out_valid, init_done
  );

  modport slave (
    input  password, start, data_in, in_valid,
    output in_ready, data_out, out_valid, init_done
  );
endinterface

// File: rtl/stream_encrypt.sv
// RC4 byte stream encryptor: the key byte is repeated 256 times for the KSA,
// then each accepted plaintext byte is XORed with the next PRGA keystream byte.
module stream_encrypt #(
  parameter int n = 8
) (
  input  logic             clk,
  input  logic             rst,
  stream_encrypt_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, INIT, KSA, READY, GEN} state_t;

  localparam logic [n-1:0] ONE = n'(1);

  state_t       r_state;
  logic [n-1:0] r_s [256];
  logic [n-1:0] r_i;
  logic [n-1:0] r_j;
  logic [n-1:0] r_key;
  logic [n-1:0] r_byte;
  logic [n-1:0] r_data_out;
  logic [8:0]   r_cnt;
  logic         r_out_valid;
  logic         r_init_done;

  logic         w_start;
  logic         w_accept;
  logic         w_last;
  logic [n-1:0] w_i_inc;
  logic [n-1:0] w_s_i;
  logic [n-1:0] w_s_iinc;
  logic [n-1:0] w_ksa_jn;
  logic [n-1:0] w_prga_jn;
  logic [n-1:0] w_ks_idx;
  logic [n-1:0] w_ks;

  logic         w_we_a;
  logic [n-1:0] w_addr_a;
  logic [n-1:0] w_dat_a;
  logic         w_we_b;
  logic [n-1:0] w_addr_b;
  logic [n-1:0] w_dat_b;

  assign w_start   = bus.start && ((r_state == IDLE) || (r_state == READY));
  assign w_accept  = (r_state == READY) && bus.in_valid && !bus.start;
  assign w_last    = (r_cnt == 9'd255);
  assign w_i_inc   = r_i + ONE;
  assign w_s_i     = r_s[r_i];
  assign w_s_iinc  = r_s[w_i_inc];
  assign w_ksa_jn  = r_j + w_s_i + r_key;
  assign w_prga_jn = r_j + w_s_iinc;
  assign w_ks_idx  = r_s[r_i] + r_s[r_j];
  assign w_ks      = r_s[w_ks_idx];

  assign bus.in_ready  = (r_state == READY);
  assign bus.data_out  = r_data_out;
  assign bus.out_valid = r_out_valid;
  assign bus.init_done = r_init_done;

  // Select the two S-box write ports for the fill, KSA swap and PRGA swap.
  always_comb begin
    w_we_a   = 1'b0;
    w_addr_a = '0;
    w_dat_a  = '0;
    w_we_b   = 1'b0;
    w_addr_b = '0;
    w_dat_b  = '0;
    case (r_state)
      INIT: begin
        w_we_a   = 1'b1;
        w_addr_a = r_i;
        w_dat_a  = r_i;
      end
      KSA: begin
        w_we_a   = 1'b1;
        w_addr_a = r_i;
        w_dat_a  = r_s[w_ksa_jn];
        w_we_b   = 1'b1;
        w_addr_b = w_ksa_jn;
        w_dat_b  = w_s_i;
      end
      READY: begin
        if (w_accept) begin
          w_we_a   = 1'b1;
          w_addr_a = w_i_inc;
          w_dat_a  = r_s[w_prga_jn];
          w_we_b   = 1'b1;
          w_addr_b = w_prga_jn;
          w_dat_b  = w_s_iinc;
        end
      end
      default: ;
    endcase
  end

  // S-box storage (no reset needed). Port b is written last, so when both
  // addresses coincide the slot gets back its own old value: the swap is a no-op.
  always_ff @(posedge clk) begin
    if (w_we_a) r_s[w_addr_a] <= w_dat_a;
    if (w_we_b) r_s[w_addr_b] <= w_dat_b;
  end

  // Control FSM: key schedule sequencing, byte accept and registered output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_i         <= '0;
      r_j         <= '0;
      r_key       <= '0;
      r_byte      <= '0;
      r_cnt       <= '0;
      r_data_out  <= '0;
      r_out_valid <= 1'b0;
      r_init_done <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      if (w_start) begin
        r_key       <= bus.password;
        r_i         <= '0;
        r_j         <= '0;
        r_cnt       <= '0;
        r_init_done <= 1'b0;
        r_state     <= INIT;
      end else begin
        case (r_state)
          IDLE: ;
          INIT: begin
            r_i   <= w_i_inc;
            r_cnt <= r_cnt + 9'd1;
            if (w_last) begin
              r_cnt   <= '0;
              r_state <= KSA;
            end
          end
          KSA: begin
            r_i   <= w_i_inc;
            r_j   <= w_ksa_jn;
            r_cnt <= r_cnt + 9'd1;
            if (w_last) begin
              r_cnt       <= '0;
              r_i         <= '0;
              r_j         <= '0;
              r_init_done <= 1'b1;
              r_state     <= READY;
            end
          end
          READY: begin
            if (w_accept) begin
              r_byte  <= bus.data_in;
              r_i     <= w_i_inc;
              r_j     <= w_prga_jn;
              r_state <= GEN;
            end
          end
          GEN: begin
            r_data_out  <= r_byte ^ w_ks;
            r_out_valid <= 1'b1;
            r_state     <= READY;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stream_encrypt.sv
// Scoreboard bench for stream_encrypt: the driver pushes expected ciphertext and
// output cycle, an independent monitor pops and compares on every out_valid.
module tb_stream_encrypt;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stream_encrypt_if #(.n(8)) bus ();
  stream_encrypt #(.n(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0] d;
    int         c;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [7:0] cap_q[$];
  logic [7:0] last_exp = 8'h00;
  logic [7:0] hello [5] = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
  logic [7:0] ct    [5];

  // Reference RC4 (key = 256 copies of one byte).
  logic [7:0] ms [256];
  logic [7:0] mi, mj;

  task automatic model_key(input logic [7:0] k);
    logic [7:0] j, t;
    j = 8'h00;
    for (int x = 0; x < 256; x++) ms[x] = 8'(x);
    for (int x = 0; x < 256; x++) begin
      j = j + ms[x] + k;
      t = ms[x]; ms[x] = ms[j]; ms[j] = t;
    end
    mi = 8'h00;
    mj = 8'h00;
  endtask

  task automatic model_ks(output logic [7:0] ks);
    logic [7:0] t, idx;
    mi = mi + 8'h01;
    mj = mj + ms[mi];
    t = ms[mi]; ms[mi] = ms[mj]; ms[mj] = t;
    idx = ms[mi] + ms[mj];
    ks = ms[idx];
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare each output pulse against the scoreboard; data_out must hold otherwise.
  always @(negedge clk) begin
    if (rst) begin
      last_exp = 8'h00;
      check("reset out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("reset data_out", {24'd0, bus.data_out}, 32'd0);
    end else if (bus.out_valid) begin
      cap_q.push_back(bus.data_out);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected out_valid: got data 0x%0h, required no output (t=%0t)", bus.data_out, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("data_out", {24'd0, bus.data_out}, {24'd0, mon_e.d});
        check("out_valid cycle", cyc, mon_e.c);
        last_exp = mon_e.d;
      end
    end else begin
      check("data_out hold", {24'd0, bus.data_out}, {24'd0, last_exp});
    end
  end

  task automatic do_start(input logic [7:0] k, output int s);
    bus.password = k;
    bus.start    = 1'b1;
    s            = cyc + 1;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.password = 8'h00;
  endtask

  task automatic wait_init(input int s);
    int t = 0;
    while (!bus.init_done && t < 700) begin
      @(negedge clk);
      t++;
    end
    check("init_done latency", cyc - s, 32'd512);
    check("in_ready after init", {31'd0, bus.in_ready}, 32'd1);
  endtask

  task automatic send(input logic [7:0] b, input logic [7:0] e, input bit b2b);
    int t = 0;
    if (b2b) check("in_ready back-to-back", {31'd0, bus.in_ready}, 32'd1);
    while (!bus.in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL in_ready wait: got timeout, required in_ready=1");
      return;
    end
    bus.data_in  = b;
    bus.in_valid = 1'b1;
    exp_q.push_back('{e, cyc + 2});
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.data_in  = 8'h00;
    @(negedge clk);
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("scoreboard drained", exp_q.size(), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, required test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s;
    logic [7:0] ks, ks0;
    bus.password = 8'h00;
    bus.start    = 1'b0;
    bus.data_in  = 8'h00;
    bus.in_valid = 1'b0;

    // Reset values
    #1;
    check("rst in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("rst init_done", {31'd0, bus.init_done}, 32'd0);
    check("rst out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst data_out", {24'd0, bus.data_out}, 32'd0);
    @(posedge clk); @(posedge clk); #2 rst = 1'b0;
    repeat (5) @(negedge clk);
    check("idle in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("idle init_done", {31'd0, bus.init_done}, 32'd0);

    // Key schedule 0x2A, then 16 zero bytes back-to-back
    do_start(8'h2A, s);
    model_key(8'h2A);
    repeat (3) @(negedge clk);
    check("init in_ready", {31'd0, bus.in_ready}, 32'd0);
    wait_init(s);
    ks0 = 8'h00;
    for (int k = 0; k < 16; k++) begin
      model_ks(ks);
      if (k == 0) ks0 = ks;
      send(8'h00, ks, k != 0);
    end
    drain();

    // Fresh start, same key, plaintext 0xFF; in_valid held during INIT is ignored
    do_start(8'h2A, s);
    bus.data_in  = 8'h77;
    bus.in_valid = 1'b1;
    repeat (100) @(negedge clk);
    bus.in_valid = 1'b0;
    bus.data_in  = 8'h00;
    wait_init(s);
    send(8'hFF, ~ks0, 1'b0);
    drain();

    // Loopback: encrypt HELLO with 0x5C, then feed ciphertext back with the same key
    cap_q.delete();
    do_start(8'h5C, s);
    model_key(8'h5C);
    wait_init(s);
    for (int k = 0; k < 5; k++) begin
      model_ks(ks);
      send(hello[k], hello[k] ^ ks, k != 0);
    end
    drain();
    check("loopback capture count", cap_q.size(), 32'd5);
    for (int k = 0; k < 5; k++) ct[k] = (k < cap_q.size()) ? cap_q[k] : 8'h00;
    do_start(8'h5C, s);
    wait_init(s);
    for (int k = 0; k < 5; k++) send(ct[k], hello[k], k != 0);
    drain();

    // Reset at edge 300 (inside KSA), then a full new schedule
    do_start(8'h2A, s);
    while (cyc < s + 299) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("ksa rst data_out", {24'd0, bus.data_out}, 32'd0);
    check("ksa rst out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("ksa rst init_done", {31'd0, bus.init_done}, 32'd0);
    check("ksa rst in_ready", {31'd0, bus.in_ready}, 32'd0);
    @(posedge clk); @(posedge clk);
    #2 rst = 1'b0;
    repeat (4) @(negedge clk);
    check("post-rst idle init_done", {31'd0, bus.init_done}, 32'd0);
    check("post-rst idle in_ready", {31'd0, bus.in_ready}, 32'd0);
    do_start(8'h2A, s);
    model_key(8'h2A);
    wait_init(s);
    for (int k = 0; k < 4; k++) begin
      model_ks(ks);
      send(8'h00, ks, k != 0);
    end
    drain();

    // Reset while a byte is in GEN: no output for it
    bus.data_in  = 8'h33;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #2 rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.data_in  = 8'h00;
    #1;
    check("gen rst out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("gen rst data_out", {24'd0, bus.data_out}, 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("no out after gen rst", {31'd0, bus.out_valid}, 32'd0);
    end
    check("gen rst idle in_ready", {31'd0, bus.in_ready}, 32'd0);

    // start and in_valid together in READY: start wins
    do_start(8'h91, s);
    wait_init(s);
    bus.password = 8'h37;
    bus.start    = 1'b1;
    bus.data_in  = 8'h11;
    bus.in_valid = 1'b1;
    s = cyc + 1;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.password = 8'h00;
    bus.data_in  = 8'h00;
    check("restart init_done drop", {31'd0, bus.init_done}, 32'd0);
    check("restart in_ready", {31'd0, bus.in_ready}, 32'd0);
    model_key(8'h37);
    wait_init(s);
    for (int k = 0; k < 3; k++) begin
      model_ks(ks);
      send(8'hA5, 8'hA5 ^ ks, k != 0);
    end
    drain();

    repeat (5) @(negedge clk);
    check("final scoreboard empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
